// File: rtl/bit_serial_alu_sequencer_if.sv
// Handshake and 1-bit ALU bundle for bit_serial_alu_sequencer.
// slave is the sequencer's view; master is the surrounding system (producer, consumer and ALU).
interface bit_serial_alu_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic             alu_a;
   logic             alu_b;
   logic [1:0]       alu_op;
   logic             alu_out;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;

   modport slave (
      input  in_valid, in_a, in_b, in_op, alu_out, out_ready,
      output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero
   );

   modport master (
      output in_valid, in_a, in_b, in_op, alu_out, out_ready,
      input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero
   );
endinterface

// File: rtl/bit_serial_alu_sequencer.sv
// Feeds a WIDTH-bit operand pair LSB-first through an external 1-bit logic ALU
// and reassembles the returned bits into a result word with a zero flag.
module bit_serial_alu_sequencer #(
   parameter int WIDTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   bit_serial_alu_sequencer_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt;
   logic             zero_q;
   logic             ready;
   logic             accept;
   logic             last_bit;

   // Each returned bit enters at the MSB, so bit i lands in position i after WIDTH shifts.
   assign res_next = {bus.alu_out, res[WIDTH-1:1]};
   assign accept   = ready & bus.in_valid;
   assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign bus.in_ready = ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         op_q   <= 2'b00;
         cnt    <= '0;
         zero_q <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            a_sh   <= bus.in_a;
            b_sh   <= bus.in_b;
            op_q   <= bus.in_op;
            cnt    <= '0;
            res    <= '0;
            zero_q <= 1'b0;
         end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_next;
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
               zero_q <= (res_next == '0);
            end
         end
      end
   end

   // The result is only exposed in DONE, so a partially assembled word never leaks out.
   always_comb begin
      state_next     = state;
      ready          = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_result = '0;
      bus.out_zero   = 1'b0;
      bus.alu_a      = 1'b0;
      bus.alu_b      = 1'b0;
      bus.alu_op     = 2'b00;
      case (state)
         IDLE: begin
            ready = ~rst;
            if (bus.in_valid && !rst) begin
               state_next = RUN;
            end
         end
         RUN: begin
            bus.alu_a  = a_sh[0];
            bus.alu_b  = b_sh[0];
            bus.alu_op = op_q;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid  = 1'b1;
            bus.out_result = res;
            bus.out_zero   = zero_q;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bit_serial_alu_sequencer.sv
// Directed bench for bit_serial_alu_sequencer with a reference 1-bit logic ALU on the alu_* side.
module tb_bit_serial_alu_sequencer;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checkCount = 0;
   int   passCount = 0;

   bit_serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   bit_serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: AND, OR, NAND, NOR
   always_comb begin
      case (bus.alu_op)
         2'b00:   bus.alu_out = bus.alu_a & bus.alu_b;
         2'b01:   bus.alu_out = bus.alu_a | bus.alu_b;
         2'b10:   bus.alu_out = ~(bus.alu_a & bus.alu_b);
         default: bus.alu_out = ~(bus.alu_a | bus.alu_b);
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount = checkCount + 1;
      assert (observed === expected) passCount = passCount + 1;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_valid = 1'b1;
   endtask

   // Starts in IDLE just after an edge, ends in the IDLE cycle following the output handshake.
   task automatic runTxn(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [7:0] expRes, input logic expZero, input bit hold);
      int lat;
      checkOutput({tag, " in_ready before accept"}, bus.in_ready, 1);
      applyStimulus(a, b, op);
      step();
      if (!hold) bus.in_valid = 1'b0;
      checkOutput({tag, " in_ready in RUN"}, bus.in_ready, 0);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      checkOutput({tag, " latency"}, lat, 9);
      checkOutput({tag, " result"}, bus.out_result, expRes);
      checkOutput({tag, " zero"}, bus.out_zero, expZero);
      step();
      checkOutput({tag, " out_valid dropped"}, bus.out_valid, 0);
      checkOutput({tag, " in_ready after done"}, bus.in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      int lat;
      int sawValid;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = 2'b00;
      bus.out_ready = 1'b1;

      // Reset
      step(); step(); step();
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset out_result", bus.out_result, 0);
      checkOutput("reset out_zero", bus.out_zero, 0);
      checkOutput("reset alu_a", bus.alu_a, 0);
      checkOutput("reset alu_b", bus.alu_b, 0);
      checkOutput("reset alu_op", bus.alu_op, 0);
      rst = 1'b0;
      #1;
      checkOutput("in_ready after reset", bus.in_ready, 1);
      step();

      runTxn("and", 8'hA5, 8'h3C, 2'b00, 8'h24, 1'b0, 1'b0);

      // Back-to-back with in_valid held high
      runTxn("or",   8'hA5, 8'h3C, 2'b01, 8'hBD, 1'b0, 1'b1);
      runTxn("nand", 8'hA5, 8'h3C, 2'b10, 8'hDB, 1'b0, 1'b1);
      runTxn("nor",  8'hA5, 8'h3C, 2'b11, 8'h42, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      step();

      runTxn("zero and", 8'hF0, 8'h0F, 2'b00, 8'h00, 1'b1, 1'b0);
      runTxn("zero or",  8'hF0, 8'h0F, 2'b01, 8'hFF, 1'b0, 1'b0);

      // Backpressure
      bus.out_ready = 1'b0;
      applyStimulus(8'h12, 8'h34, 2'b01);
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      checkOutput("bp latency", lat, 9);
      checkOutput("bp result", bus.out_result, 8'h36);
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) applyStimulus(8'hFF, 8'hFF, 2'b00);
         else bus.in_valid = 1'b0;
         step();
         checkOutput($sformatf("bp out_valid c%0d", k), bus.out_valid, 1);
         checkOutput($sformatf("bp result c%0d", k), bus.out_result, 8'h36);
         checkOutput($sformatf("bp in_ready c%0d", k), bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      checkOutput("bp in_ready at release", bus.in_ready, 0);
      step();
      checkOutput("bp out_valid after release", bus.out_valid, 0);
      checkOutput("bp in_ready after release", bus.in_ready, 1);
      step();
      checkOutput("bp operands not captured", bus.in_ready, 1);

      // Reset in RUN cycle 3
      applyStimulus(8'hA5, 8'h3C, 2'b00);
      step();
      bus.in_valid = 1'b0;
      step(); step();
      checkOutput("mid-run in_ready", bus.in_ready, 0);
      rst = 1'b1;
      step();
      checkOutput("abort out_valid", bus.out_valid, 0);
      checkOutput("abort out_result", bus.out_result, 0);
      checkOutput("abort alu_op", bus.alu_op, 0);
      rst = 1'b0;
      sawValid = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (bus.out_valid === 1'b1) sawValid++;
      end
      checkOutput("abort no stale result", sawValid, 0);
      runTxn("after abort", 8'hFF, 8'h01, 2'b11, 8'h00, 1'b1, 1'b0);

      // Bit order and opcode latching
      checkOutput("bitorder alu_op idle", bus.alu_op, 0);
      checkOutput("bitorder alu_a idle", bus.alu_a, 0);
      applyStimulus(8'h01, 8'h00, 2'b01);
      step();
      bus.in_valid = 1'b0;
      bus.in_op    = 2'b10;
      checkOutput("bitorder alu_a c1", bus.alu_a, 1);
      checkOutput("bitorder alu_b c1", bus.alu_b, 0);
      checkOutput("bitorder alu_op c1", bus.alu_op, 1);
      for (int c = 2; c <= 8; c++) begin
         step();
         checkOutput($sformatf("bitorder alu_a c%0d", c), bus.alu_a, 0);
         checkOutput($sformatf("bitorder alu_op c%0d", c), bus.alu_op, 1);
      end
      step();
      checkOutput("bitorder out_valid", bus.out_valid, 1);
      checkOutput("bitorder result", bus.out_result, 8'h01);
      checkOutput("bitorder zero", bus.out_zero, 0);
      checkOutput("bitorder alu_op done", bus.alu_op, 0);
      step();
      checkOutput("bitorder in_ready", bus.in_ready, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
